// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
// key_debounce_multi : N-channel active-low key synchroniser/debouncer
// Revision 1.0
// ============================================================================
module key_debounce_multi #(
  parameter int N_KEYS   = 4,
  parameter int IDX_W    = 2,
  parameter int CNT_W    = 20,
  parameter int CNT_MAX  = 1_000_000,
  parameter int LONG_W   = 26,
  parameter int LONG_MAX = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_value,
  output logic [N_KEYS-1:0] press_flag,
  output logic [N_KEYS-1:0] release_flag,
  output logic [N_KEYS-1:0] long_flag,
  output logic              press_any,
  output logic [IDX_W-1:0]  press_idx
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FILTER_DOWN = 2'd1,
    HELD        = 2'd2,
    FILTER_UP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_MAX - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX - 1);
  // lcnt parks one past the firing value so the long pulse cannot repeat.
  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_MAX);
  localparam bit                LONG_EN   = (LONG_MAX != 0);

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] kv_nx;
  logic [N_KEYS-1:0] press_nx;
  logic [N_KEYS-1:0] rel_nx;
  logic [N_KEYS-1:0] long_nx;
  logic [IDX_W-1:0]  idx_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [LONG_W-1:0] lcnt, lcnt_nx;
    logic              s;
    logic              ch_kv, ch_press, ch_rel, ch_long;

    assign s = sync2[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        cnt   <= '0;
        lcnt  <= '0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        lcnt  <= lcnt_nx;
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      lcnt_nx  = lcnt;
      ch_kv    = key_value[i];
      ch_press = 1'b0;
      ch_rel   = 1'b0;
      ch_long  = 1'b0;
      case (state)
        IDLE: begin
          if (!s) begin
            state_nx = FILTER_DOWN;
            cnt_nx   = '0;
          end
        end
        FILTER_DOWN: begin
          if (s) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nx = HELD;
            ch_kv    = 1'b0;
            ch_press = 1'b1;
            lcnt_nx  = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        HELD: begin
          if (LONG_EN) begin
            if (lcnt == LONG_LAST) begin
              ch_long = 1'b1;
              lcnt_nx = LONG_SAT;
            end else if (lcnt != LONG_SAT) begin
              lcnt_nx = lcnt + 1'b1;
            end
          end
          if (s) begin
            state_nx = FILTER_UP;
            cnt_nx   = '0;
          end
        end
        FILTER_UP: begin
          // A dip back low resumes the hold without losing long-press progress.
          if (!s) begin
            state_nx = HELD;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nx = IDLE;
            ch_kv    = 1'b1;
            ch_rel   = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end

    assign kv_nx[i]    = ch_kv;
    assign press_nx[i] = ch_press;
    assign rel_nx[i]   = ch_rel;
    assign long_nx[i]  = ch_long;
  end

  always_comb begin
    idx_nx = '0;
    for (int j = N_KEYS - 1; j >= 0; j--) begin
      if (press_nx[j]) idx_nx = IDX_W'(j);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_value    <= '1;
      press_flag   <= '0;
      release_flag <= '0;
      long_flag    <= '0;
      press_any    <= 1'b0;
      press_idx    <= '0;
    end else begin
      key_value    <= kv_nx;
      press_flag   <= press_nx;
      release_flag <= rel_nx;
      long_flag    <= long_nx;
      press_any    <= |press_nx;
      if (|press_nx) press_idx <= idx_nx;
    end
  end

endmodule
`default_nettype wire
